ddr3_layer_sequencer: RTL and testbench

Sequences the DDR3 engine wrapper through a programmed list of layers. For each layer it selects the input and output parameter IDs and pulses the read start. It counts returned read beats, then pulses the write start and counts written beats before moving to the next layer. It sits between the host/config path and the DDR3 wrapper, and replaces manual start strobing.

---
 rtl/ddr3_layer_sequencer_pkg.sv | 41 ++++
 rtl/ddr3_layer_table.sv | 28 ++
 rtl/ddr3_layer_sequencer.sv | 169 ++++++++++++++++
 tb/tb_ddr3_layer_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_layer_sequencer_pkg.sv
// Shared types for the DDR3 layer sequencer: FSM states, layer-table entry
// layout and the parameter-ID widths used by the DDR3 wrapper.
package ddr3_layer_sequencer_pkg;

  localparam int IN_ID_W      = 4;
  localparam int OUT_ID_W     = 3;
  localparam int ENTRY_BEAT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CALWAIT = 3'd1,
    ST_CFG     = 3'd2,
    ST_RD_GO   = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_WR_GO   = 3'd5,
    ST_WR_WAIT = 3'd6,
    ST_NEXT    = 3'd7
  } seq_state_e;

  typedef struct packed {
    logic [IN_ID_W-1:0]      in_id;
    logic [OUT_ID_W-1:0]     out_id;
    logic [ENTRY_BEAT_W-1:0] rd_beats;
    logic [ENTRY_BEAT_W-1:0] wr_beats;
  } layer_entry_t;

  function automatic layer_entry_t make_entry(
    input logic [IN_ID_W-1:0]      in_id,
    input logic [OUT_ID_W-1:0]     out_id,
    input logic [ENTRY_BEAT_W-1:0] rd_beats,
    input logic [ENTRY_BEAT_W-1:0] wr_beats
  );
    layer_entry_t e;
    e.in_id    = in_id;
    e.out_id   = out_id;
    e.rd_beats = rd_beats;
    e.wr_beats = wr_beats;
    return e;
  endfunction

endpackage

// File: rtl/ddr3_layer_table.sv
// Layer program storage: one entry per layer, synchronous write port and a
// combinational read port indexed by the sequencer.
module ddr3_layer_table
  import ddr3_layer_sequencer_pkg::*;
#(
  parameter int MAX_LAYERS = 16,
  parameter int LIDX_W     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LIDX_W-1:0] addr,
  input  layer_entry_t      wr_entry,
  input  logic [LIDX_W-1:0] rd_idx,
  output layer_entry_t      rd_entry
);

  layer_entry_t mem_r [MAX_LAYERS];

  // Table write port; contents are host-programmed and carry no reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wr_entry;
    end
  end

  assign rd_entry = mem_r[rd_idx];

endmodule

// File: rtl/ddr3_layer_sequencer.sv
// Walks the DDR3 engine wrapper through a programmed list of layers: per layer
// it sets the param IDs, strobes read, counts read beats, then strobes write.
module ddr3_layer_sequencer
  import ddr3_layer_sequencer_pkg::*;
#(
  parameter int MAX_LAYERS = 16,
  parameter int LIDX_W     = 4,
  parameter int BEAT_W     = 32,
  parameter int CFG_WAIT   = 2,
  parameter int TIMEOUT_W  = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_calib_complete,
  input  logic                tbl_we,
  input  logic [LIDX_W-1:0]   tbl_addr,
  input  logic [IN_ID_W-1:0]  tbl_in_id,
  input  logic [OUT_ID_W-1:0] tbl_out_id,
  input  logic [BEAT_W-1:0]   tbl_rd_beats,
  input  logic [BEAT_W-1:0]   tbl_wr_beats,
  input  logic                run,
  input  logic [LIDX_W:0]     num_layers,
  input  logic                dn_input_vld,
  input  logic                wr_beat,
  output logic                start_read_input,
  output logic [IN_ID_W-1:0]  input_param_id,
  output logic                start_write_output,
  output logic [OUT_ID_W-1:0] output_param_id,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [LIDX_W-1:0]   layer_idx
);

  localparam int               CFG_W    = (CFG_WAIT > 2) ? $clog2(CFG_WAIT) : 1;
  localparam logic [CFG_W-1:0] CFG_LAST = CFG_W'(CFG_WAIT - 1);
  localparam logic [LIDX_W:0]  MAX_NUM  = (LIDX_W+1)'(MAX_LAYERS);

  seq_state_e           state_r, state_nx_s;
  layer_entry_t         wr_entry_s, rd_entry_s;
  logic [LIDX_W-1:0]    cfg_idx_s, last_idx_r;
  logic [BEAT_W-1:0]    rd_cnt_r, wr_cnt_r;
  logic [CFG_W-1:0]     cfg_cnt_r;
  logic [TIMEOUT_W-1:0] wd_r;
  logic                 run_ok_s, rd_beat_s, wr_beat_s, wd_hit_s, load_cfg_s, in_wait_s;

  assign wr_entry_s = make_entry(tbl_in_id, tbl_out_id,
                                 ENTRY_BEAT_W'(tbl_rd_beats), ENTRY_BEAT_W'(tbl_wr_beats));

  // Entering CFG from NEXT must already see the incremented layer index
  assign cfg_idx_s = (state_r == ST_NEXT) ? layer_idx + LIDX_W'(1) : layer_idx;

  ddr3_layer_table #(
    .MAX_LAYERS (MAX_LAYERS),
    .LIDX_W     (LIDX_W)
  ) u_table (
    .clk      (clk),
    .we       (tbl_we),
    .addr     (tbl_addr),
    .wr_entry (wr_entry_s),
    .rd_idx   (cfg_idx_s),
    .rd_entry (rd_entry_s)
  );

  assign run_ok_s   = run && (state_r == ST_IDLE) && (num_layers != '0) && (num_layers <= MAX_NUM);
  assign rd_beat_s  = (state_r == ST_RD_WAIT) && dn_input_vld;
  assign wr_beat_s  = (state_r == ST_WR_WAIT) && wr_beat;
  assign in_wait_s  = (state_r == ST_RD_WAIT) || (state_r == ST_WR_WAIT);
  assign wd_hit_s   = in_wait_s && !rd_beat_s && !wr_beat_s && (&wd_r);
  assign load_cfg_s = (state_nx_s == ST_CFG) && (state_r != ST_CFG);

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run_ok_s) state_nx_s = ST_CALWAIT;
        else          state_nx_s = ST_IDLE;
      end
      ST_CALWAIT: begin
        if (init_calib_complete) state_nx_s = ST_CFG;
        else                     state_nx_s = ST_CALWAIT;
      end
      ST_CFG: begin
        if (cfg_cnt_r == CFG_LAST) state_nx_s = ST_RD_GO;
        else                       state_nx_s = ST_CFG;
      end
      ST_RD_GO: begin
        if (rd_cnt_r == '0) state_nx_s = ST_WR_GO;
        else                state_nx_s = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_beat_s && (rd_cnt_r == BEAT_W'(1))) state_nx_s = ST_WR_GO;
        else if (wd_hit_s)                          state_nx_s = ST_IDLE;
        else                                        state_nx_s = ST_RD_WAIT;
      end
      ST_WR_GO: begin
        if (wr_cnt_r == '0) state_nx_s = ST_NEXT;
        else                state_nx_s = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (wr_beat_s && (wr_cnt_r == BEAT_W'(1))) state_nx_s = ST_NEXT;
        else if (wd_hit_s)                          state_nx_s = ST_IDLE;
        else                                        state_nx_s = ST_WR_WAIT;
      end
      ST_NEXT: begin
        if (layer_idx == last_idx_r) state_nx_s = ST_IDLE;
        else                         state_nx_s = ST_CFG;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, counters, watchdog and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= ST_IDLE;
      last_idx_r         <= '0;
      rd_cnt_r           <= '0;
      wr_cnt_r           <= '0;
      cfg_cnt_r          <= '0;
      wd_r               <= '0;
      start_read_input   <= 1'b0;
      start_write_output <= 1'b0;
      input_param_id     <= '0;
      output_param_id    <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      timeout            <= 1'b0;
      layer_idx          <= '0;
    end else begin
      state_r            <= state_nx_s;
      busy               <= (state_nx_s != ST_IDLE);
      done               <= (state_r == ST_NEXT) && (state_nx_s == ST_IDLE);
      // Counts are loaded on CFG entry, so they are valid when the GO state is chosen
      start_read_input   <= (state_nx_s == ST_RD_GO) && (rd_cnt_r != '0);
      start_write_output <= (state_nx_s == ST_WR_GO) && (wr_cnt_r != '0);

      if (run_ok_s) begin
        layer_idx  <= '0;
        last_idx_r <= LIDX_W'(num_layers - (LIDX_W+1)'(1));
        timeout    <= 1'b0;
      end else if (wd_hit_s) begin
        timeout    <= 1'b1;
      end else if ((state_r == ST_NEXT) && (state_nx_s == ST_CFG)) begin
        layer_idx  <= layer_idx + LIDX_W'(1);
      end

      if (load_cfg_s) begin
        input_param_id  <= rd_entry_s.in_id;
        output_param_id <= rd_entry_s.out_id;
        rd_cnt_r        <= BEAT_W'(rd_entry_s.rd_beats);
        wr_cnt_r        <= BEAT_W'(rd_entry_s.wr_beats);
        cfg_cnt_r       <= '0;
      end else begin
        if (state_r == ST_CFG)             cfg_cnt_r <= cfg_cnt_r + CFG_W'(1);
        if (rd_beat_s && (rd_cnt_r != '0)) rd_cnt_r  <= rd_cnt_r - BEAT_W'(1);
        if (wr_beat_s && (wr_cnt_r != '0)) wr_cnt_r  <= wr_cnt_r - BEAT_W'(1);
      end

      if (!in_wait_s || rd_beat_s || wr_beat_s || (state_nx_s != state_r)) begin
        wd_r <= '0;
      end else begin
        wd_r <= wd_r + TIMEOUT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ddr3_layer_sequencer.sv
// Scoreboard bench for ddr3_layer_sequencer: directed layer programs push the
// expected strobe/done events, a negedge monitor pops and compares them.
module tb_ddr3_layer_sequencer;

  localparam int MAX_LAYERS = 16;
  localparam int LIDX_W     = 4;
  localparam int BEAT_W     = 32;
  localparam int CFG_WAIT   = 2;
  localparam int TIMEOUT_W  = 8;

  localparam int EV_RD   = 0;
  localparam int EV_WR   = 1;
  localparam int EV_DONE = 2;

  logic              clk, rst_n, init_calib_complete, tbl_we, run, dn_input_vld, wr_beat;
  logic [LIDX_W-1:0] tbl_addr;
  logic [3:0]        tbl_in_id;
  logic [2:0]        tbl_out_id;
  logic [BEAT_W-1:0] tbl_rd_beats, tbl_wr_beats;
  logic [LIDX_W:0]   num_layers;
  logic              start_read_input, start_write_output, busy, done, timeout;
  logic [3:0]        input_param_id;
  logic [2:0]        output_param_id;
  logic [LIDX_W-1:0] layer_idx;

  typedef struct {
    int kind;
    int in_id;
    int out_id;
    int lidx;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  ddr3_layer_sequencer #(
    .MAX_LAYERS (MAX_LAYERS),
    .LIDX_W     (LIDX_W),
    .BEAT_W     (BEAT_W),
    .CFG_WAIT   (CFG_WAIT),
    .TIMEOUT_W  (TIMEOUT_W)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .tbl_we              (tbl_we),
    .tbl_addr            (tbl_addr),
    .tbl_in_id           (tbl_in_id),
    .tbl_out_id          (tbl_out_id),
    .tbl_rd_beats        (tbl_rd_beats),
    .tbl_wr_beats        (tbl_wr_beats),
    .run                 (run),
    .num_layers          (num_layers),
    .dn_input_vld        (dn_input_vld),
    .wr_beat             (wr_beat),
    .start_read_input    (start_read_input),
    .input_param_id      (input_param_id),
    .start_write_output  (start_write_output),
    .output_param_id     (output_param_id),
    .busy                (busy),
    .done                (done),
    .timeout             (timeout),
    .layer_idx           (layer_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input int in_id, input int out_id, input int lidx);
    ev_t e;
    e.kind = kind; e.in_id = in_id; e.out_id = out_id; e.lidx = lidx;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual=kind %0d required=no event", kind);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_layer_idx", layer_idx, e.lidx);
      if (kind == EV_DONE) begin
        chk("busy_at_done", busy, 0);
      end else begin
        chk("event_in_id", input_param_id, e.in_id);
        chk("event_out_id", output_param_id, e.out_id);
      end
    end
  endtask

  // Monitor: every strobe or done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (start_read_input)   check_event(EV_RD);
      if (start_write_output) check_event(EV_WR);
      if (done)               check_event(EV_DONE);
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return start_read_input;
      1:       return start_write_output;
      2:       return done;
      3:       return timeout;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int bound, input string name, output int n);
    n = 0;
    while (!sig(sel) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!sig(sel)) begin
      checks++;
      errors++;
      $display("FAIL %s actual=not seen required=seen within %0d cycles", name, bound);
    end
  endtask

  task automatic write_entry(input int a, input int in_id, input int out_id, input int rd, input int wr);
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = LIDX_W'(a); tbl_in_id = 4'(in_id); tbl_out_id = 3'(out_id);
    tbl_rd_beats = BEAT_W'(rd); tbl_wr_beats = BEAT_W'(wr);
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic pulse_run(input int n);
    @(negedge clk);
    run = 1'b1; num_layers = (LIDX_W+1)'(n);
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic beats(input int sel, input int n);
    @(negedge clk);
    repeat (n) begin
      if (sel == 0) dn_input_vld = 1'b1; else wr_beat = 1'b1;
      @(negedge clk);
    end
    dn_input_vld = 1'b0;
    wr_beat = 1'b0;
  endtask

  task automatic run_layer(input int rd, input int wr);
    int n;
    wait_sig(0, 20, "wait_read_start", n);
    beats(0, rd);
    if (wr > 0) begin
      wait_sig(1, 20, "wait_write_start", n);
      beats(1, wr);
    end
  endtask

  initial begin : stim
    int n;
    int early;
    rst_n = 1'b1; init_calib_complete = 1'b1; tbl_we = 1'b0; run = 1'b0;
    dn_input_vld = 1'b0; wr_beat = 1'b0; tbl_addr = '0; tbl_in_id = '0; tbl_out_id = '0;
    tbl_rd_beats = '0; tbl_wr_beats = '0; num_layers = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {start_read_input, start_write_output, busy, done, timeout,
                          input_param_id, output_param_id, layer_idx}, 0);
    rst_n = 1'b1;

    // Single layer: IDs 3/5, 4 read beats, 2 write beats
    write_entry(0, 3, 5, 4, 2);
    expect_ev(EV_RD, 3, 5, 0); expect_ev(EV_WR, 3, 5, 0); expect_ev(EV_DONE, 0, 0, 0);
    pulse_run(1);
    chk("busy_after_run", busy, 1);
    wait_sig(0, 20, "wait_read_start", n);
    chk("run_to_read_latency", n + 1, 4);
    beats(0, 4);
    wait_sig(1, 20, "wait_write_start", n);
    chk("last_read_beat_to_write", n, 0);
    beats(1, 2);
    wait_sig(2, 20, "wait_done", n);
    chk("last_write_beat_to_done", n, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    // Three layers in order
    write_entry(0, 1, 0, 2, 1);
    write_entry(1, 2, 1, 1, 2);
    write_entry(2, 7, 6, 3, 1);
    expect_ev(EV_RD, 1, 0, 0); expect_ev(EV_WR, 1, 0, 0);
    expect_ev(EV_RD, 2, 1, 1); expect_ev(EV_WR, 2, 1, 1);
    expect_ev(EV_RD, 7, 6, 2); expect_ev(EV_WR, 7, 6, 2);
    expect_ev(EV_DONE, 0, 0, 2);
    pulse_run(3);
    run_layer(2, 1);
    run_layer(1, 2);
    run_layer(3, 1);
    wait_sig(2, 20, "wait_done_3layer", n);
    repeat (5) @(negedge clk);
    chk("layer_idx_after_3layer", layer_idx, 2);
    chk("busy_after_3layer", busy, 0);

    // Calibration held low for 100 cycles
    init_calib_complete = 1'b0;
    write_entry(0, 4, 2, 1, 1);
    expect_ev(EV_RD, 4, 2, 0); expect_ev(EV_WR, 4, 2, 0); expect_ev(EV_DONE, 0, 0, 0);
    pulse_run(1);
    early = 0;
    repeat (100) begin
      @(negedge clk);
      if (start_read_input) early++;
    end
    chk("no_read_before_calib", early, 0);
    chk("busy_in_calwait", busy, 1);
    init_calib_complete = 1'b1;
    wait_sig(0, 20, "wait_read_after_calib", n);
    chk("calib_to_read_latency", n, 3);
    beats(0, 1);
    wait_sig(1, 20, "wait_write_calib", n);
    beats(1, 1);
    wait_sig(2, 20, "wait_done_calib", n);

    // No write phase, one surplus read beat
    write_entry(0, 5, 3, 2, 0);
    expect_ev(EV_RD, 5, 3, 0); expect_ev(EV_DONE, 0, 0, 0);
    pulse_run(1);
    wait_sig(0, 20, "wait_read_zero_wr", n);
    beats(0, 3);
    wait_sig(2, 20, "wait_done_zero_wr", n);
    chk("zero_write_done_latency", n, 1);

    // Out-of-range program lengths are ignored
    pulse_run(0);
    chk("run_zero_ignored", busy, 0);
    pulse_run(MAX_LAYERS + 1);
    chk("run_too_long_ignored", busy, 0);
    repeat (4) @(negedge clk);

    // Watchdog: read beats withheld
    write_entry(0, 6, 4, 3, 1);
    expect_ev(EV_RD, 6, 4, 0);
    pulse_run(1);
    wait_sig(0, 20, "wait_read_timeout", n);
    repeat (200) @(negedge clk);
    chk("busy_before_timeout", busy, 1);
    chk("timeout_not_early", timeout, 0);
    wait_sig(3, 150, "wait_timeout", n);
    chk("timeout_window", ((200 + n) >= 255 && (200 + n) <= 258) ? 1 : 0, 1);
    chk("busy_after_timeout", busy, 0);
    repeat (3) @(negedge clk);
    chk("timeout_sticky", timeout, 1);
    write_entry(0, 6, 4, 1, 1);
    expect_ev(EV_RD, 6, 4, 0); expect_ev(EV_WR, 6, 4, 0); expect_ev(EV_DONE, 0, 0, 0);
    pulse_run(1);
    chk("timeout_cleared_by_run", timeout, 0);
    run_layer(1, 1);
    wait_sig(2, 20, "wait_done_after_timeout", n);

    // Asynchronous reset in the middle of RD_WAIT
    write_entry(0, 9, 7, 3, 1);
    expect_ev(EV_RD, 9, 7, 0);
    pulse_run(1);
    wait_sig(0, 20, "wait_read_reset", n);
    beats(0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_busy", busy, 0);
    chk("reset_mid_ids", {input_param_id, output_param_id}, 0);
    chk("reset_mid_pulses", {start_read_input, start_write_output, done, timeout}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    expect_ev(EV_RD, 9, 7, 0); expect_ev(EV_WR, 9, 7, 0); expect_ev(EV_DONE, 0, 0, 0);
    pulse_run(1);
    wait_sig(0, 20, "wait_read_after_reset", n);
    chk("restart_latency", n + 1, 4);
    beats(0, 3);
    wait_sig(1, 20, "wait_write_after_reset", n);
    beats(1, 1);
    wait_sig(2, 20, "wait_done_after_reset", n);
    repeat (3) @(negedge clk);

    chk("events_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
